// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a producer of binary values and the
// bin2bcd_seq converter.
//   start : request a conversion of bin (producer -> converter)
//   bin   : unsigned binary operand, WIDTH bits (producer -> converter)
//   busy  : conversion in progress (converter -> producer)
//   done  : one-cycle completion pulse (converter -> producer)
//   bcd   : packed BCD result, digit 0 (units) in bcd[3:0] (converter -> producer)
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Feeds the BCD-to-7-segment decoder; result digits are held until the
// next completion.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   ena   : global enable; low freezes every register
//   bus   : bin2bcd_seq_if slave (start, bin in; busy, done, bcd out)
//
// States:
//   IDLE | waiting for start; busy=0, bcd holds the last result
//   CONV | one shift-and-add-3 iteration per enabled edge; busy=1
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int TW = BW + WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [WIDTH-1:0] sh_bin;
  logic [BW-1:0]    sh_bcd;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcd_r;
  logic             done_r;

  logic [BW-1:0]    t_bcd;
  logic [TW-1:0]    shifted;
  logic             accept;
  logic             last_iter;

  // Add-3 correction, digit by digit with no inter-digit carry. Digits are
  // always 0..9 here, so a corrected digit (8..12) still fits in 4 bits.
  always_comb begin
    t_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd5) begin
        t_bcd[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
      end else begin
        t_bcd[4*i +: 4] = sh_bcd[4*i +: 4];
      end
    end
  end

  // The MSB of sh_bin falls into bit 0 of the BCD field.
  assign shifted   = {t_bcd, sh_bin} << 1;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (ena && bus.start) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (ena && last_iter) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_bin <= '0;
      sh_bcd <= '0;
      cnt    <= '0;
      bcd_r  <= '0;
      done_r <= 1'b0;
    end else if (ena) begin
      done_r <= 1'b0;
      if (accept) begin
        sh_bin <= bus.bin;
        sh_bcd <= '0;
        cnt    <= '0;
      end else if (state == CONV) begin
        sh_bin <= shifted[WIDTH-1:0];
        sh_bcd <= shifted[TW-1:WIDTH];
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          bcd_r  <= shifted[TW-1:WIDTH];
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == CONV);
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] exp_q[$];
  int          exp_rem  = 0;
  bit          exp_done = 1'b0;
  bit          last_en  = 1'b0;
  logic [11:0] held     = 12'h000;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic check(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model: a conversion takes W enabled edges after acceptance.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_rem  = 0;
        exp_done = 1'b0;
        last_en  = 1'b0;
        held     = 12'h000;
      end else begin
        last_en = ena;
        if (ena) begin
          exp_done = 1'b0;
          if (exp_rem > 0) begin
            exp_rem--;
            if (exp_rem == 0) exp_done = 1'b1;
          end else if (bus.start) begin
            exp_q.push_back(ref_bcd(int'(bus.bin)));
            exp_rem = W;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model, pops on each fresh done.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      check(bus.busy === (exp_rem > 0), "busy", 32'(bus.busy), 32'(exp_rem > 0));
      check(bus.done === exp_done, "done", 32'(bus.done), 32'(exp_done));
      check(!(bus.busy === 1'b1 && bus.done === 1'b1), "busy_and_done",
            32'({bus.busy, bus.done}), 32'h0);
      if (bus.done === 1'b1 && last_en) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "spurious_done", 32'(bus.bcd), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check(bus.bcd === e, "bcd_result", 32'(bus.bcd), 32'(e));
          held = e;
        end
      end else begin
        check(bus.bcd === held, "bcd_hold", 32'(bus.bcd), 32'(held));
      end
    end
  end

  task automatic go(input int v);
    bus.bin   = 8'(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v;
    int guard;
    int c;
    bus.start = 1'b0;
    bus.bin   = '0;
    @(negedge clk);
    @(negedge clk);
    check(bus.bcd === 12'h000, "reset_bcd", 32'(bus.bcd), 32'h0);
    check(bus.busy === 1'b0, "reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    ena   = 1'b1;
    idle(2);

    // Directed values
    go(0);   idle(10);
    go(255); idle(10);
    go(99);  idle(10);
    go(100); idle(10);

    // start held high, bin stepping 0..255 once per accepted conversion
    bus.start = 1'b1;
    v = 0;
    guard = 0;
    while (v < 256 && guard < 4000) begin
      if (exp_rem == 0) begin
        bus.bin = 8'(v);
        v++;
      end else begin
        bus.bin = 8'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    check(v == 256, "start_hold_timeout", 32'(v), 32'd256);
    bus.start = 1'b0;
    idle(12);

    // Start during a conversion is ignored
    go(37);
    idle(2);
    go(200);
    idle(12);

    // ena low for 5 cycles mid-conversion of 128
    go(128);
    c = 0;
    while (c < 40) begin
      c++;
      ena = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (bus.done === 1'b1) break;
    end
    ena = 1'b1;
    check(c == 13, "ena_latency", 32'(c), 32'd13);
    idle(4);

    // Reset mid-conversion aborts
    go(255); idle(10);
    go(42);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check(bus.bcd === 12'h000, "abort_bcd", 32'(bus.bcd), 32'h0);
    check(bus.busy === 1'b0, "abort_busy", 32'(bus.busy), 32'h0);
    idle(12);
    go(42); idle(12);

    // Random traffic with ena gaps and occasional reset
    repeat (600) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.bin   = 8'($urandom);
      ena       = ($urandom_range(0, 4) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    ena       = 1'b1;
    rst_n     = 1'b1;
    idle(12);

    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
